// File: rtl/gen_gamma_encoder.sv
// Gamma (additive) stream-cipher encoder: md = od + nk with carry kept, nk from a Galois LFSR.
// One output register with pass-through on downstream ready; the keystream advances only on accept.
module gen_gamma_encoder #(
  parameter int              SIZE  = 8,
  parameter logic [SIZE-1:0] TAPS  = 8'hB8,
  parameter int              CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_load,
  input  logic [SIZE-1:0]  seed,
  input  logic [SIZE-1:0]  od,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [SIZE:0]    md,
  output logic [SIZE-1:0]  nk,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             seeded,
  output logic [CNT_W-1:0] word_cnt
);

  typedef enum logic {
    UNSEEDED = 1'b0,
    SEEDED   = 1'b1
  } state_t;

  state_t           r_state;
  logic [SIZE-1:0]  r_key;
  logic [SIZE:0]    r_md;
  logic [SIZE-1:0]  r_nk;
  logic             r_out_valid;
  logic             r_seeded;
  logic [CNT_W-1:0] r_word_cnt;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_out_xfer;
  logic [SIZE-1:0]  w_seed_val;
  logic [SIZE-1:0]  w_key_next;
  logic [SIZE:0]    w_sum;

  function automatic logic [SIZE-1:0] lfsr_next(input logic [SIZE-1:0] k);
    lfsr_next = k[0] ? ((k >> 1) ^ TAPS) : (k >> 1);
  endfunction

  // An all-zero LFSR state would lock up, so a zero seed is promoted to 1.
  assign w_seed_val = (seed == '0) ? {{(SIZE-1){1'b0}}, 1'b1} : seed;
  assign w_key_next = lfsr_next(r_key);
  assign w_sum      = {1'b0, od} + {1'b0, r_key};

  assign w_in_ready = r_seeded & ~seed_load & (~r_out_valid | out_ready);
  assign w_accept   = in_valid & w_in_ready;
  assign w_out_xfer = r_out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= UNSEEDED;
      r_key       <= '0;
      r_md        <= '0;
      r_nk        <= '0;
      r_out_valid <= 1'b0;
      r_seeded    <= 1'b0;
      r_word_cnt  <= '0;
    end else begin
      case (r_state)
        UNSEEDED: if (seed_load) r_state <= SEEDED;
        SEEDED:   r_state <= SEEDED;
        default:  r_state <= UNSEEDED;
      endcase

      // Seed load excludes accept in the same cycle because in_ready drops.
      if (seed_load) begin
        r_key      <= w_seed_val;
        r_seeded   <= 1'b1;
        r_word_cnt <= '0;
      end else if (w_accept) begin
        r_key      <= w_key_next;
        r_word_cnt <= r_word_cnt + 1'b1;
      end

      if (w_accept) begin
        r_md        <= w_sum;
        r_nk        <= r_key;
        r_out_valid <= 1'b1;
      end else if (w_out_xfer) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign md        = r_md;
  assign nk        = r_nk;
  assign out_valid = r_out_valid;
  assign seeded    = r_seeded;
  assign word_cnt  = r_word_cnt;

endmodule

// File: doc/gen_gamma_encoder.md
Name: gen_gamma_encoder

Overview:
Gamma (additive stream-cipher) encoder; the transmit end of the gen_gamma link, feeding the gen_gamma_decoder.
- Accepts SIZE-bit original data words over a valid/ready handshake.
- Generates a keystream word per accepted input from an internal Galois LFSR.
- Emits mixed data md = od + nk (SIZE+1 bits, carry kept) together with the noise key nk used for that word.
- Decoder recovers od as md − nk.

Parameters:
SIZE, 8, data and key width; md is SIZE+1 bits.
TAPS, 8'hB8, Galois LFSR feedback mask, SIZE bits.
CNT_W, 16, width of accepted-word counter.

Ports:
clk  input  1  clock, all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
seed_load  input  1  load keystream seed this cycle.
seed  input  SIZE  seed value; 0 is substituted by 1.
od  input  SIZE  original data word.
in_valid  input  1  od valid.
in_ready  output  1  encoder can accept od this cycle.
md  output  SIZE+1  mixed data to decoder.
nk  output  SIZE  noise key to decoder.
out_valid  output  1  md/nk valid.
out_ready  input  1  downstream accepts md/nk.
seeded  output  1  keystream initialised since reset.
word_cnt  output  CNT_W  words accepted since last seed load.

Behaviour:
- Clock and reset: one clock (clk); rst is asynchronous and active-high.
- Reset values (asynchronous on rst=1): md=0, nk=0, out_valid=0, seeded=0, word_cnt=0, key register=0. State is UNSEEDED.
- States:
  - UNSEEDED: in_ready=0. seed_load moves to SEEDED.
  - SEEDED: normal operation. Only rst returns to UNSEEDED.
- Seed load:
  - Acts in either state: key <= (seed==0) ? 1 : seed; seeded <= 1; word_cnt <= 0.
  - Does not flush or modify a pending md/nk/out_valid.
- in_ready (combinational) = seeded & ~seed_load & (~out_valid | out_ready).
  - Single output register with pass-through on ready, so back-to-back accepts run one word per cycle.
- Accept event (in_valid & in_ready at a rising edge):
  - md <= {1'b0,od} + {1'b0,key}, nk <= key, out_valid <= 1.
  - key <= lfsr_next(key); word_cnt <= word_cnt+1, wrapping at 2^CNT_W.
- Latency: 1 cycle from accept to out_valid.
- lfsr_next(k) = k[0] ? ((k>>1) ^ TAPS) : (k>>1).
  - With the defaults, seed 0x01 gives the sequence 0x01, 0xB8, 0x5C, 0x2E, 0x17, 0xB3, …
- Output handshake:
  - Transfer when out_valid & out_ready.
  - If there is no new accept in the same cycle, out_valid <= 0; md/nk hold their last values.
  - While out_valid & ~out_ready: md, nk, out_valid held stable and in_ready=0.
- Simultaneous events:
  - seed_load with in_valid: no accept (in_ready=0). The seed is loaded, and od must be re-presented.
  - Output transfer and new accept in the same cycle: the new word replaces the old one and out_valid stays 1.
- Arithmetic: the sum is never truncated; md[SIZE] is the carry. Max md = 2·(2^SIZE−1).
- Reset mid-transfer: a pending word is discarded, the keystream is lost, and a new seed_load is required.
- Keystream advances only on accept, never on stall, idle or output transfer.

Test Plan:
- Reset, then no seed: in_valid=1, od=0x55 for 5 cycles -> in_ready=0, out_valid=0, md=0, nk=0, seeded=0.
- seed_load with seed=0x01, then od=0x10, 0xFF, 0x80 back-to-back, out_ready=1:
  - md/nk = 0x011/0x01, 0x1B7/0xB8, 0x0DC/0x5C on consecutive cycles.
  - word_cnt=3.
- Same stream with out_ready=0 for 3 cycles after the first accept:
  - md=0x011, nk=0x01 held and in_ready=0.
  - After release, the next words still use keys 0xB8 and then 0x5C.
- seed=0x00 loaded -> first accepted od=0x00 gives md=0x001, nk=0x01.
- seed_load=1 with in_valid=1 in the same cycle -> no accept, word_cnt=0. The word is accepted next cycle using the new seed as nk.
- Reset asserted between cycles of the second scenario:
  - Outputs go to zero immediately, without waiting for a clock edge.
  - After reseed with 0x01, keys restart at 0x01.
  - A loopback decoder model checks md−nk==od for 256 random words.
